// File: rtl/ipv4_hdr_pkg.sv
// Shared constants, request record and checksum helper for the IPv4 header generator.
package ipv4_hdr_pkg;

    localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
    localparam logic [15:0] IPV4_MIN_HDR_LEN = 16'd20;

    // Byte offsets of each field inside the 20-byte header (byte 0 is transmitted first)
    localparam int unsigned OFF_VER_IHL   = 0;
    localparam int unsigned OFF_TOS       = 1;
    localparam int unsigned OFF_TOTAL_LEN = 2;
    localparam int unsigned OFF_ID        = 4;
    localparam int unsigned OFF_FLAGS     = 6;
    localparam int unsigned OFF_TTL       = 8;
    localparam int unsigned OFF_PROTO     = 9;
    localparam int unsigned OFF_CSUM      = 10;
    localparam int unsigned OFF_SRC       = 12;
    localparam int unsigned OFF_DST       = 16;

    localparam int unsigned HDR_BYTES = 20;

    // Bit positions inside the 2-bit error vector
    localparam int unsigned ERR_LEN = 0;
    localparam int unsigned ERR_CH  = 1;

    // Per-request record carried through the FIFO and stage A
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] total_len;
        logic [5:0]  dscp;
        logic [7:0]  ttl;
        logic        df;
        logic [15:0] id;
        logic [1:0]  err;
    } hdr_fields_t;

    // Two end-around-carry folds of a 20-bit word sum, then one's complement
    function automatic logic [15:0] csum_fold(input logic [19:0] sum);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
        s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
        return ~s2[15:0];
    endfunction

endpackage

// File: rtl/hdr_req_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Depth must be a power of two; pointers wrap naturally.
module hdr_req_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] FullLevel = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_push = push_i && (count_q != FullLevel);
        do_pop  = pop_i && (count_q != '0);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AddrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AddrW + 1)'(1);
            2'b01:   count_d = count_q - (AddrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == FullLevel);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;

endmodule

// File: rtl/ipv4_header_gen_mc.sv
// Multi-channel IPv4 header generator: request FIFO, stage A (word sum),
// stage B (fold, complement, header assembly).
// Build option IPV4_ID_PER_CH_EN: defined gives one Identification counter per
// channel; undefined gives a single counter shared by all channels.
module ipv4_header_gen_mc
    import ipv4_hdr_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  PROTOCOL    = 8'd17,
    parameter logic [7:0]  TTL_DEFAULT = 8'd64,
    parameter logic [15:0] ID_INIT     = 16'h0000,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [31:0]       in_src_ip,
    input  logic [31:0]       in_dst_ip,
    input  logic [15:0]       in_total_len,
    input  logic [5:0]        in_dscp,
    input  logic [7:0]        in_ttl,
    input  logic              in_df,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [159:0]      out_header,
    output logic [15:0]       out_checksum,
    output logic [CH_W-1:0]   out_ch,
    output logic [1:0]        out_err,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int unsigned HdrMsb = HDR_BYTES * 8 - 1;
    localparam int unsigned EntryW = CH_W + $bits(hdr_fields_t);

    hdr_fields_t       req_f, head_f;
    logic [CH_W-1:0]   head_ch;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [1:0]        req_err;
    logic [15:0]       req_id;

    logic              a_adv, b_adv;
    logic [19:0]       head_sum;
    logic              a_valid_q, a_valid_d;
    logic [CH_W-1:0]   a_ch_q, a_ch_d;
    hdr_fields_t       a_f_q, a_f_d;
    logic [19:0]       a_sum_q, a_sum_d;

    logic [15:0]       csum;
    logic [159:0]      hdr;
    logic              out_valid_q, out_valid_d;
    logic [159:0]      out_header_q, out_header_d;
    logic [15:0]       out_checksum_q, out_checksum_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [1:0]        out_err_q, out_err_d;

    // Request classification, TTL substitution and FIFO write data
    always_comb begin
        req_err          = '0;
        req_err[ERR_LEN] = (in_total_len < IPV4_MIN_HDR_LEN);
        req_err[ERR_CH]  = (32'(in_ch) >= NUM_CH);
        push             = in_valid && !fifo_full;
        req_f.src_ip     = in_src_ip;
        req_f.dst_ip     = in_dst_ip;
        req_f.total_len  = in_total_len;
        req_f.dscp       = in_dscp;
        req_f.ttl        = (in_ttl == 8'd0) ? TTL_DEFAULT : in_ttl;
        req_f.df         = in_df;
        req_f.id         = req_id;
        req_f.err        = req_err;
        fifo_wdata       = {in_ch, req_f};
    end

`ifdef IPV4_ID_PER_CH_EN
    logic [NUM_CH-1:0][15:0] id_q, id_d;

    // Per-channel ID: errored requests get 0 and never touch a counter
    always_comb begin
        id_d   = id_q;
        req_id = 16'h0000;
        if (req_err == 2'b00) begin
            req_id = id_q[in_ch];
            if (push) begin
                id_d[in_ch] = id_q[in_ch] + 16'd1;
            end
        end
    end

    // ID counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= {NUM_CH{ID_INIT}};
        end else begin
            id_q <= id_d;
        end
    end
`else
    logic [15:0] id_q, id_d;

    // Shared ID: errored requests get 0 and leave the counter alone
    always_comb begin
        id_d   = id_q;
        req_id = 16'h0000;
        if (req_err == 2'b00) begin
            req_id = id_q;
            if (push) begin
                id_d = id_q + 16'd1;
            end
        end
    end

    // ID counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= ID_INIT;
        end else begin
            id_q <= id_d;
        end
    end
`endif

    hdr_req_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Stage A: pop the head and register the sum of the ten header words
    always_comb begin
        b_adv            = !out_valid_q || out_ready;
        a_adv            = !a_valid_q || b_adv;
        pop              = a_adv && !fifo_empty;
        {head_ch, head_f} = fifo_rdata;
        head_sum = {4'h0, IPV4_VER_IHL, head_f.dscp, 2'b00}
                 + {4'h0, head_f.total_len}
                 + {4'h0, head_f.id}
                 + {4'h0, 1'b0, head_f.df, 14'b0}
                 + {4'h0, head_f.ttl, PROTOCOL}
                 + {4'h0, head_f.src_ip[31:16]}
                 + {4'h0, head_f.src_ip[15:0]}
                 + {4'h0, head_f.dst_ip[31:16]}
                 + {4'h0, head_f.dst_ip[15:0]};
        a_valid_d = a_valid_q;
        a_ch_d    = a_ch_q;
        a_f_d     = a_f_q;
        a_sum_d   = a_sum_q;
        if (a_adv) begin
            a_valid_d = !fifo_empty;
            if (pop) begin
                a_ch_d  = head_ch;
                a_f_d   = head_f;
                a_sum_d = head_sum;
            end
        end
    end

    // Stage B: fold the sum and assemble the header; hold while stalled
    always_comb begin
        csum = csum_fold(a_sum_q);
        hdr  = '0;
        hdr[HdrMsb - 8*OFF_VER_IHL   -: 8]  = IPV4_VER_IHL;
        hdr[HdrMsb - 8*OFF_TOS       -: 8]  = {a_f_q.dscp, 2'b00};
        hdr[HdrMsb - 8*OFF_TOTAL_LEN -: 16] = a_f_q.total_len;
        hdr[HdrMsb - 8*OFF_ID        -: 16] = a_f_q.id;
        hdr[HdrMsb - 8*OFF_FLAGS     -: 16] = {1'b0, a_f_q.df, 14'b0};
        hdr[HdrMsb - 8*OFF_TTL       -: 8]  = a_f_q.ttl;
        hdr[HdrMsb - 8*OFF_PROTO     -: 8]  = PROTOCOL;
        hdr[HdrMsb - 8*OFF_CSUM      -: 16] = csum;
        hdr[HdrMsb - 8*OFF_SRC       -: 32] = a_f_q.src_ip;
        hdr[HdrMsb - 8*OFF_DST       -: 32] = a_f_q.dst_ip;
        out_valid_d    = out_valid_q;
        out_header_d   = out_header_q;
        out_checksum_d = out_checksum_q;
        out_ch_d       = out_ch_q;
        out_err_d      = out_err_q;
        if (b_adv) begin
            out_valid_d = a_valid_q;
            if (a_valid_q) begin
                out_header_d   = hdr;
                out_checksum_d = csum;
                out_ch_d       = a_ch_q;
                out_err_d      = a_f_q.err;
            end
        end
    end

    // Pipeline registers for both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q      <= 1'b0;
            a_ch_q         <= '0;
            a_f_q          <= '0;
            a_sum_q        <= '0;
            out_valid_q    <= 1'b0;
            out_header_q   <= '0;
            out_checksum_q <= '0;
            out_ch_q       <= '0;
            out_err_q      <= '0;
        end else begin
            a_valid_q      <= a_valid_d;
            a_ch_q         <= a_ch_d;
            a_f_q          <= a_f_d;
            a_sum_q        <= a_sum_d;
            out_valid_q    <= out_valid_d;
            out_header_q   <= out_header_d;
            out_checksum_q <= out_checksum_d;
            out_ch_q       <= out_ch_d;
            out_err_q      <= out_err_d;
        end
    end

    assign in_ready     = !fifo_full;
    assign out_valid    = out_valid_q;
    assign out_header   = out_header_q;
    assign out_checksum = out_checksum_q;
    assign out_ch       = out_ch_q;
    assign out_err      = out_err_q;

endmodule

// File: tb/tb_ipv4_header_gen_mc.sv
// Directed bench for ipv4_header_gen_mc. A second instance with NUM_CH=3 exercises
// the out-of-range channel error, which a 2-bit channel port cannot reach at NUM_CH=4.
module tb_ipv4_header_gen_mc;

`ifdef IPV4_ID_PER_CH_EN
    localparam bit PerCh = 1'b1;
`else
    localparam bit PerCh = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_df, out_valid, out_ready;
    logic [1:0]   in_ch, out_ch, out_err;
    logic [31:0]  in_src_ip, in_dst_ip;
    logic [15:0]  in_total_len, out_checksum;
    logic [5:0]   in_dscp;
    logic [7:0]   in_ttl;
    logic [159:0] out_header;
    logic [2:0]   fifo_level;

    logic         d3_in_ready, d3_out_valid;
    logic [1:0]   d3_out_ch, d3_out_err;
    logic [15:0]  d3_out_checksum;
    logic [159:0] d3_out_header;
    logic [2:0]   d3_fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [159:0] exp_hdr [8];
    logic [1:0]   exp_ch  [8];
    logic [1:0]   exp_err [8];

    always #5 clk = ~clk;

    ipv4_header_gen_mc dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ch        (in_ch),
        .in_src_ip    (in_src_ip),
        .in_dst_ip    (in_dst_ip),
        .in_total_len (in_total_len),
        .in_dscp      (in_dscp),
        .in_ttl       (in_ttl),
        .in_df        (in_df),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_header   (out_header),
        .out_checksum (out_checksum),
        .out_ch       (out_ch),
        .out_err      (out_err),
        .fifo_level   (fifo_level)
    );

    ipv4_header_gen_mc #(
        .NUM_CH (3)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (d3_in_ready),
        .in_ch        (in_ch),
        .in_src_ip    (in_src_ip),
        .in_dst_ip    (in_dst_ip),
        .in_total_len (in_total_len),
        .in_dscp      (in_dscp),
        .in_ttl       (in_ttl),
        .in_df        (in_df),
        .out_valid    (d3_out_valid),
        .out_ready    (out_ready),
        .out_header   (d3_out_header),
        .out_checksum (d3_out_checksum),
        .out_ch       (d3_out_ch),
        .out_err      (d3_out_err),
        .fifo_level   (d3_fifo_level)
    );

    // Reference header: fields laid out, then one's-complement sum over byte pairs
    function automatic logic [159:0] mk_hdr(input logic [31:0] src, input logic [31:0] dst,
                                            input logic [15:0] len, input logic [15:0] id,
                                            input logic [5:0] dscp, input logic [7:0] ttl,
                                            input logic df);
        logic [159:0] h;
        logic [31:0]  s;
        h = {8'h45, dscp, 2'b00, len, id, 1'b0, df, 14'b0, ttl, 8'd17, 16'h0000, src, dst};
        s = 32'd0;
        for (int i = 0; i < 20; i += 2) begin
            s = s + {16'h0000, h[159-8*i -: 8], h[151-8*i -: 8]};
        end
        while (s[31:16] != 16'h0000) begin
            s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        end
        h[79:64] = ~s[15:0];
        return h;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one request for exactly one rising edge
    task automatic push_req(input logic [1:0] ch, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input logic [5:0] dscp,
                            input logic [7:0] ttl, input logic df);
        in_ch        = ch;
        in_src_ip    = src;
        in_dst_ip    = dst;
        in_total_len = len;
        in_dscp      = dscp;
        in_ttl       = ttl;
        in_df        = df;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_tests++;
        if (out_header !== 160'd0 || out_checksum !== 16'd0 || out_ch !== 2'd0
            || out_err !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_payload: got hdr %h csum %h ch %0d err %b expected all 0",
                     out_header, out_checksum, out_ch, out_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        push_req(2'd0, 32'hc0a8_0001, 32'hc0a8_00c7, 16'h0073, 6'd0, 8'h40, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_e1: got valid %b expected 0", out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_e2: got valid %b expected 0", out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL latency_e3: got valid %b expected 1", out_valid);
        end
        n_tests++;
        if (out_header !== 160'h4500_0073_0000_4000_4011_B861_c0a8_0001_c0a8_00c7) begin
            n_fail++; $display("FAIL basic_header: got %h expected %h", out_header,
                               160'h4500_0073_0000_4000_4011_B861_c0a8_0001_c0a8_00c7);
        end
        n_tests++;
        if (out_checksum !== 16'hB861 || out_err !== 2'b00 || out_ch !== 2'd0) begin
            n_fail++; $display("FAIL basic_csum_err: got csum %h err %b ch %0d expected b861 00 0",
                               out_checksum, out_err, out_ch);
        end
        tick();
    endtask

    task automatic test_ids();
        int k;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_req(2'd1, 32'h0a00_0001, 32'h0a00_0002, 16'h0040 + 16'(i), 6'h2e, 8'h20, 1'b0);
            exp_hdr[i] = mk_hdr(32'h0a00_0001, 32'h0a00_0002, 16'h0040 + 16'(i), 16'(i),
                                6'h2e, 8'h20, 1'b0);
            exp_ch[i]  = 2'd1;
        end
        push_req(2'd2, 32'h0a00_0003, 32'h0a00_0004, 16'h0050, 6'h01, 8'h80, 1'b1);
        exp_hdr[3] = mk_hdr(32'h0a00_0003, 32'h0a00_0004, 16'h0050, PerCh ? 16'd0 : 16'd3,
                            6'h01, 8'h80, 1'b1);
        exp_ch[3]  = 2'd2;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_header !== exp_hdr[k] || out_ch !== exp_ch[k]) begin
                    n_fail++; $display("FAIL ids_%0d: got ch %0d hdr %h expected ch %0d hdr %h",
                                       k, out_ch, out_header, exp_ch[k], exp_hdr[k]);
                end
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 4) begin
            n_fail++; $display("FAIL ids_count: got %0d headers expected 4", k);
        end
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
`ifdef IPV4_ID_PER_CH_EN
        force dut.id_q = {16'hFFFF, 48'h0};
`else
        force dut.id_q = 16'hFFFF;
`endif
        tick();
        release dut.id_q;
        push_req(2'd3, 32'h0102_0304, 32'h0506_0708, 16'h05dc, 6'h0a, 8'h11, 1'b0);
        push_req(2'd3, 32'h0102_0304, 32'h0506_0708, 16'h05dc, 6'h0a, 8'h11, 1'b0);
        exp_hdr[0] = mk_hdr(32'h0102_0304, 32'h0506_0708, 16'h05dc, 16'hFFFF, 6'h0a, 8'h11, 1'b0);
        exp_hdr[1] = mk_hdr(32'h0102_0304, 32'h0506_0708, 16'h05dc, 16'h0000, 6'h0a, 8'h11, 1'b0);
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 30 && k < 2; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_header !== exp_hdr[k]) begin
                    n_fail++; $display("FAIL wrap_%0d: got id %h hdr %h expected %h",
                                       k, out_header[127:112], out_header, exp_hdr[k]);
                end
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d headers expected 2", k);
        end
    endtask

    task automatic test_errors();
        int k;
        do_reset();
        push_req(2'd0, 32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0030, 6'h00, 8'h00, 1'b1);
        push_req(2'd0, 32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0010, 6'h00, 8'h40, 1'b0);
        push_req(2'd0, 32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0030, 6'h00, 8'h40, 1'b0);
        push_req(2'd3, 32'h0c0c_0c0c, 32'h0d0d_0d0d, 16'h0028, 6'h00, 8'h40, 1'b0);
        exp_hdr[0] = mk_hdr(32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0030, 16'd0, 6'h00, 8'h40, 1'b1);
        exp_hdr[1] = mk_hdr(32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0010, 16'd0, 6'h00, 8'h40, 1'b0);
        exp_hdr[2] = mk_hdr(32'h0a0a_0a0a, 32'h0b0b_0b0b, 16'h0030, 16'd1, 6'h00, 8'h40, 1'b0);
        exp_hdr[3] = mk_hdr(32'h0c0c_0c0c, 32'h0d0d_0d0d, 16'h0028, PerCh ? 16'd0 : 16'd2,
                            6'h00, 8'h40, 1'b0);
        exp_err[0] = 2'b00;
        exp_err[1] = 2'b01;
        exp_err[2] = 2'b00;
        exp_err[3] = 2'b00;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_header !== exp_hdr[k] || out_err !== exp_err[k]) begin
                    n_fail++; $display("FAIL err_%0d: got err %b hdr %h expected err %b hdr %h",
                                       k, out_err, out_header, exp_err[k], exp_hdr[k]);
                end
                if (k == 0) begin
                    n_tests++;
                    if (out_header[95:88] !== 8'h40) begin
                        n_fail++; $display("FAIL ttl_default: got %h expected 40",
                                           out_header[95:88]);
                    end
                end
                if (k == 3) begin
                    n_tests++;
                    if (d3_out_valid !== 1'b1 || d3_out_err !== 2'b10
                        || d3_out_header[127:112] !== 16'h0000) begin
                        n_fail++;
                        $display("FAIL err_ch: got valid %b err %b id %h expected 1 10 0000",
                                 d3_out_valid, d3_out_err, d3_out_header[127:112]);
                    end
                end
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 4) begin
            n_fail++; $display("FAIL err_count: got %0d headers expected 4", k);
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_req(2'd0, 32'h1111_0000 + 32'(i), 32'h2222_0000, 16'h0100 + 16'(i), 6'h08,
                     8'h30, 1'b1);
            exp_hdr[i] = mk_hdr(32'h1111_0000 + 32'(i), 32'h2222_0000, 16'h0100 + 16'(i),
                                16'(i), 6'h08, 8'h30, 1'b1);
        end
        n_tests++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: got ready %b level %0d valid %b expected 0 4 1",
                               in_ready, fifo_level, out_valid);
        end
        n_tests++;
        if (out_header !== exp_hdr[0]) begin
            n_fail++; $display("FAIL bp_head: got %h expected %h", out_header, exp_hdr[0]);
        end
        repeat (3) tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_header !== exp_hdr[0] || fifo_level !== 3'd4) begin
            n_fail++; $display("FAIL bp_stable: got valid %b level %0d hdr %h expected 1 4 %h",
                               out_valid, fifo_level, out_header, exp_hdr[0]);
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_header !== exp_hdr[k]) begin
                    n_fail++; $display("FAIL bp_order_%0d: got %h expected %h",
                                       k, out_header, exp_hdr[k]);
                end
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 6 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_count: got %0d headers valid %b expected 6 0",
                               k, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int  k;
        bit  seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_req(2'd0, 32'h3333_0000, 32'h4444_0000, 16'h0200, 6'h00, 8'h40, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL flush: got valid %b level %0d expected 0 0",
                               out_valid, fifo_level);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL flush_no_output: got a header expected none");
        end
        push_req(2'd0, 32'h5555_0000, 32'h6666_0000, 16'h0300, 6'h00, 8'h40, 1'b0);
        exp_hdr[0] = mk_hdr(32'h5555_0000, 32'h6666_0000, 16'h0300, 16'd0, 6'h00, 8'h40, 1'b0);
        k = 0;
        for (int c = 0; c < 20 && k < 1; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_header !== exp_hdr[0]) begin
                    n_fail++; $display("FAIL id_restart: got %h expected %h",
                                       out_header, exp_hdr[0]);
                end
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 1) begin
            n_fail++; $display("FAIL id_restart_count: got %0d headers expected 1", k);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_ch        = '0;
        in_src_ip    = '0;
        in_dst_ip    = '0;
        in_total_len = '0;
        in_dscp      = '0;
        in_ttl       = '0;
        in_df        = 1'b0;
        test_reset();
        test_basic();
        test_ids();
        test_wrap();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
